// File: rtl/count_checker_pkg.sv
// Shared types and constants for the count checker: FSM state encoding,
// sample classification and datapath widths.
package count_checker_pkg;

    localparam int CNT_W          = 4;
    localparam int ERR_W          = 8;
    localparam int LOCK_COUNT_DEF = 4;

    typedef enum logic [1:0] {
        ST_EMPTY   = 2'd0,
        ST_ACQUIRE = 2'd1,
        ST_TRACK   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        CLS_HOLD,
        CLS_STEP,
        CLS_MISS
    } cls_t;

    // A sample either repeats the last value, advances it by one modulo 16, or misses.
    function automatic cls_t classify(input logic [CNT_W-1:0] last,
                                      input logic [CNT_W-1:0] sample);
        if (sample == last)
            return CLS_HOLD;
        else if (sample == CNT_W'(last + CNT_W'(1)))
            return CLS_STEP;
        else
            return CLS_MISS;
    endfunction

endpackage

// File: rtl/cc_sync2.sv
// Two-flop synchronizer for asynchronous control/data inputs, reset to zero.
module cc_sync2 #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/tt_um_reuel_pandher_count_checker.sv
// Counter-sequence checker: locks onto a +1 stream, flags misses and wraps.
// Define COUNT_CHECK_SYNC_EN to pass ui_in[5:0] through a two-flop synchronizer.
module tt_um_reuel_pandher_count_checker
    import count_checker_pkg::*;
#(
    parameter int LOCK_COUNT = LOCK_COUNT_DEF
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    logic [5:0] ctl;

`ifdef COUNT_CHECK_SYNC_EN
    cc_sync2 #(.WIDTH(6)) u_sync (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (ui_in[5:0]),
        .q     (ctl)
    );
`else
    assign ctl = ui_in[5:0];
`endif

    logic unused;
    assign unused = &{1'b0, ena, ui_in[7:6], uio_in};

    logic [CNT_W-1:0] sample;
    logic             chk_en;
    logic             clr;
    assign sample = ctl[3:0];
    assign chk_en = ctl[4];
    assign clr    = ctl[5];

    state_t           state,    state_next;
    logic [CNT_W-1:0] last,     last_next;
    logic [CNT_W-1:0] good_run, run_next;
    logic [ERR_W-1:0] err_cnt,  err_next;
    logic             fault,    fault_next;
    logic             locked,   locked_next;
    logic             mismatch, mismatch_next;
    logic             wrap,     wrap_next;

    cls_t             cls;
    logic [CNT_W-1:0] run_inc;
    assign cls     = classify(last, sample);
    assign run_inc = good_run + CNT_W'(1);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_next    = state;
        last_next     = last;
        run_next      = good_run;
        err_next      = err_cnt;
        fault_next    = fault;
        mismatch_next = 1'b0;
        wrap_next     = 1'b0;

        if (chk_en) begin
            unique case (state)
                ST_EMPTY: begin
                    last_next  = sample;
                    run_next   = '0;
                    state_next = ST_ACQUIRE;
                end
                ST_ACQUIRE: begin
                    if (cls == CLS_STEP) begin
                        last_next = sample;
                        run_next  = run_inc;
                        if (run_inc == CNT_W'(LOCK_COUNT))
                            state_next = ST_TRACK;
                    end else if (cls == CLS_MISS) begin
                        last_next = sample;
                        run_next  = '0;
                    end
                end
                ST_TRACK: begin
                    last_next = sample;
                    if (cls == CLS_MISS) begin
                        if (err_cnt != '1)
                            err_next = err_cnt + ERR_W'(1);
                        fault_next    = 1'b1;
                        mismatch_next = 1'b1;
                        run_next      = '0;
                        state_next    = ST_ACQUIRE;
                    end else if (cls == CLS_STEP && last == '1) begin
                        wrap_next = 1'b1;
                    end
                end
                default: state_next = ST_EMPTY;
            endcase
        end

        // Clear wins over a same-cycle error; the FSM move above still happens.
        if (clr) begin
            err_next   = '0;
            fault_next = 1'b0;
        end

        locked_next = (state_next == ST_TRACK);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_EMPTY;
            last     <= '0;
            good_run <= '0;
            err_cnt  <= '0;
            fault    <= 1'b0;
            locked   <= 1'b0;
            mismatch <= 1'b0;
            wrap     <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state    <= state_next;
            last     <= last_next;
            good_run <= run_next;
            err_cnt  <= err_next;
            fault    <= fault_next;
            locked   <= locked_next;
            mismatch <= mismatch_next;
            wrap     <= wrap_next;
        end
    end

    assign uo_out  = {wrap, mismatch, fault, locked, last};
    assign uio_out = err_cnt;
    assign uio_oe  = 8'hFF;

endmodule
